truth_table_capture: RTL
========================

Name: truth_table_capture

Overview:
- Sequential reader for our 7-input single-output combinational functions. It drives every input assignment x = 0 .. 2^N_INPUTS-1 into a function-under-test and samples its output.
- It assembles the 2^N-bit truth table and its ones-count.
- The function-under-test is combinational or pipelined; it is wired x -> f_in externally.
- The captured table feeds classification checks and lets us compare a netlist against its hex signature.

Parameters:
- N_INPUTS, 7, number of function inputs; truth table width is TT_W = 2^N_INPUTS.
- SETTLE_CYCLES, 1, clock cycles x is held before f_in is sampled; legal range 1..15; covers pipelined DUTs.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; honoured only in IDLE
- x  out  N_INPUTS  assignment driven to the function-under-test; x[0] is the index LSB
- f_in  in  1  function-under-test output
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when the sweep completes
- tt  out  TT_W  captured truth table; tt[i] = f(x=i); tt[TT_W-1] is the MSB of the hex signature
- tt_valid  out  1  tt and ones_count hold a complete sweep
- ones_count  out  N_INPUTS+1  number of 1 bits in tt (0..TT_W)

Behaviour:
- Reset, applied on any rising edge in any state, including mid-sweep:
  - state=IDLE, x=0, busy=0, done=0, tt=0, tt_valid=0, ones_count=0, all counters=0.
  - A sweep interrupted by reset is discarded; no done pulse is generated.
- States and transitions: IDLE -> SWEEP -> FINISH -> IDLE.
- IDLE, on an edge with start=1:
  - Go to SWEEP.
  - Set x=0, settle counter=0, tt=0, ones_count=0, tt_valid=0.
  - Raise busy.
- SWEEP:
  - x is held for exactly SETTLE_CYCLES cycles.
  - f_in is sampled on the SETTLE_CYCLES-th edge after x took its current value.
  - On that edge: tt[x] <= f_in; ones_count += f_in.
  - If x != TT_W-1: x <= x+1 and the settle counter restarts. x never wraps.
  - If x == TT_W-1: go to FINISH, keeping x at TT_W-1.
- FINISH, one cycle:
  - done=1, tt_valid=1, busy=0.
  - Next edge goes to IDLE with done=0.
  - tt_valid stays 1 until the next accepted start or reset.
- Latency: start accepted at edge E0 -> last sample at edge E0 + TT_W*SETTLE_CYCLES -> done high for the following cycle.
  - Default parameters: 128 cycles of busy, then done.
- start while busy or in FINISH: ignored; no queueing.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- In IDLE, x holds its last value; it is 0 after reset.
- tt bits not yet written during a sweep read as 0.
- ones_count width N_INPUTS+1 guarantees no overflow at an all-ones table (value TT_W).
- f_in is treated as synchronous to clk; no synchroniser.

Decomposition:
- Shared package tt_pkg holds:
  - the N_INPUTS default;
  - the TT_W function;
  - the state enum {IDLE, SWEEP, FINISH};
  - a settle-counter width constant (4 bits).
- One natural sub-module, tt_sweep_counter:
  - owns x and the settle counter;
  - inputs clear and enable; outputs sample_strobe and last (x==TT_W-1 with sample_strobe).
- The top level keeps the FSM, the tt shift/write logic and ones_count.

Test Plan:
- f_in tied 0, default params, start pulse:
  - busy for 128 cycles, then one done pulse;
  - tt=0, ones_count=0, tt_valid=1.
- f_in = x[0]:
  - tt = 0xAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  - ones_count=64.
- f_in = majority(x[0],x[1],x[2]) combinational:
  - tt = 0xE8 repeated 16 times;
  - ones_count=64.
- SETTLE_CYCLES=3, DUT = x[6]&x[5] through a 2-stage register pipeline:
  - tt = 0xFFFF_FFFF_0000_0000_0000_0000_0000_0000;
  - ones_count=32;
  - done at exactly 384 cycles after start.
- rst asserted at x=50 mid-sweep:
  - next cycle busy=0, tt=0, tt_valid=0, x=0;
  - no done pulse;
  - a fresh start produces a correct full sweep.
- start pulsed at x=10 during a sweep and again during FINISH:
  - both ignored;
  - exactly one done pulse; tt is unchanged from an undisturbed sweep.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture block.
package tt_pkg;

  localparam int N_INPUTS_DEFAULT = 7;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sweep_counter.sv
// Walks x through 0..2^N-1, holding each value for SETTLE_CYCLES clocks
// and flagging the edge on which the function output should be sampled.
module tt_sweep_counter
  import tt_pkg::*;
#(
  parameter int N_INPUTS      = N_INPUTS_DEFAULT,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  output logic [N_INPUTS-1:0] x,
  output logic                sample_strobe,
  output logic                last
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] X_LAST      = '1;

  logic [N_INPUTS-1:0] x_q, x_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  always_comb begin
    sample_strobe = enable && (settle_q == SETTLE_LAST);
    last          = sample_strobe && (x_q == X_LAST);
  end

  // x saturates at its last value so FINISH/IDLE still show the final input.
  always_comb begin
    x_d      = x_q;
    settle_d = settle_q;
    if (clear) begin
      x_d      = '0;
      settle_d = '0;
    end else if (enable) begin
      if (sample_strobe) begin
        settle_d = '0;
        if (!last) begin
          x_d = x_q + 1'b1;
        end
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      settle_q <= '0;
    end else begin
      x_q      <= x_d;
      settle_q <= settle_d;
    end
  end

  assign x = x_q;

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every input assignment of a single-output function and captures
// its truth table plus ones-count.
module truth_table_capture
  import tt_pkg::*;
#(
  parameter int  N_INPUTS      = N_INPUTS_DEFAULT,
  parameter int  SETTLE_CYCLES = 1,
  localparam int TT_W          = tt_width(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] x,
  input  logic                f_in,
  output logic                busy,
  output logic                done,
  output logic [TT_W-1:0]     tt,
  output logic                tt_valid,
  output logic [N_INPUTS:0]   ones_count
);

  state_e state_q, state_d;

  logic [TT_W-1:0]   tt_q, tt_d;
  logic              tt_valid_q, tt_valid_d;
  logic [N_INPUTS:0] ones_count_q, ones_count_d;

  logic accept;
  logic sample_strobe;
  logic last;

  assign accept = (state_q == IDLE) && start;

  tt_sweep_counter #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept),
    .enable        (state_q == SWEEP),
    .x             (x),
    .sample_strobe (sample_strobe),
    .last          (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (last)  state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SWEEP);
    done = (state_q == FINISH);
  end

  // Table bits are written in place at index x; unwritten bits stay 0.
  always_comb begin
    tt_d         = tt_q;
    tt_valid_d   = tt_valid_q;
    ones_count_d = ones_count_q;
    if (accept) begin
      tt_d         = '0;
      tt_valid_d   = 1'b0;
      ones_count_d = '0;
    end else if (sample_strobe) begin
      tt_d[x]      = f_in;
      ones_count_d = ones_count_q + (N_INPUTS + 1)'(f_in);
      if (last) begin
        tt_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q         <= '0;
      tt_valid_q   <= 1'b0;
      ones_count_q <= '0;
    end else begin
      tt_q         <= tt_d;
      tt_valid_q   <= tt_valid_d;
      ones_count_q <= ones_count_d;
    end
  end

  assign tt         = tt_q;
  assign tt_valid   = tt_valid_q;
  assign ones_count = ones_count_q;

endmodule
